wb_commit_unit: RTL

//  Parametrised writeback/commit stage. Registers the M->W pipeline bundle, selects and

---
 rtl/wb_commit_unit_if.sv | 47 ++++
 rtl/wb_commit_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit_if.sv
// Writeback bus: M-stage bundle in, aux result channel, register-file write port out.
// The master side drives the bundle and aux offers; the slave side is the commit unit.
interface wb_commit_unit_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned AUX_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(AUX_DEPTH) + 1;

  logic              in_valid;
  logic              in_we;
  logic [REG_AW-1:0] in_dst;
  logic [1:0]        in_res_sel;
  logic [2:0]        in_ld_type;
  logic [1:0]        in_byte_off;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;

  logic              aux_valid;
  logic              aux_ready;
  logic [REG_AW-1:0] aux_dst;
  logic [DATA_W-1:0] aux_data;

  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_src_aux;
  logic [CNT_W-1:0]  aux_count;
  logic              misalign;

  modport master (
    output in_valid, in_we, in_dst, in_res_sel, in_ld_type, in_byte_off,
    output in_pc, in_alu, in_mem,
    output aux_valid, aux_dst, aux_data,
    input  aux_ready,
    input  rf_we, rf_wa, rf_wd, rf_src_aux, aux_count, misalign
  );

  modport slave (
    input  in_valid, in_we, in_dst, in_res_sel, in_ld_type, in_byte_off,
    input  in_pc, in_alu, in_mem,
    input  aux_valid, aux_dst, aux_data,
    output aux_ready,
    output rf_we, rf_wa, rf_wd, rf_src_aux, aux_count, misalign
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: registers the M->W bundle, forms the result, and owns the single
// register-file write port shared with an in-order FIFO of long-latency (aux) results.
module wb_commit_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned AUX_DEPTH = 4,
  parameter int unsigned LINK_OFS  = 8
) (
  input logic           clk,
  input logic           reset_n,
  wb_commit_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(AUX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] dst;
    logic [1:0]        sel;
    logic [2:0]        ld;
    logic [1:0]        off;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } wreg_t;

  wreg_t             r_w;
  logic [REG_AW-1:0] r_q_dst  [AUX_DEPTH];
  logic [DATA_W-1:0] r_q_data [AUX_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_cnt;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_result;
  logic              w_pipe_wr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rf_we;
  logic [REG_AW-1:0] w_rf_wa;
  logic [DATA_W-1:0] w_rf_wd;
  logic              w_rf_src_aux;

  // W-reg: no stall, loads every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w <= '0;
    end else begin
      r_w.valid <= bus.in_valid;
      r_w.we    <= bus.in_we;
      r_w.dst   <= bus.in_dst;
      r_w.sel   <= bus.in_res_sel;
      r_w.ld    <= bus.in_ld_type;
      r_w.off   <= bus.in_byte_off;
      r_w.pc    <= bus.in_pc;
      r_w.alu   <= bus.in_alu;
      r_w.mem   <= bus.in_mem;
    end
  end

  // Little-endian lane select; a half load uses only off[1], so a misaligned half still writes
  always_comb begin
    w_byte = 8'(r_w.mem >> {r_w.off, 3'b000});
    w_half = 16'(r_w.mem >> {r_w.off[1], 4'b0000});
    w_ext  = r_w.mem;
    case (r_w.ld)
      3'd1:    w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'd2:    w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      3'd3:    w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      3'd4:    w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = r_w.mem;
    endcase
  end

  always_comb begin
    w_result = r_w.alu;
    case (r_w.sel)
      2'd1:    w_result = w_ext;
      2'd2:    w_result = r_w.pc + DATA_W'(LINK_OFS);
      default: w_result = r_w.alu;
    endcase
  end

  assign w_pipe_wr = r_w.valid & r_w.we & (r_w.dst != '0);
  assign w_full    = (r_cnt == CNT_W'(AUX_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = bus.aux_valid & ~w_full;
  assign w_pop     = ~w_pipe_wr & ~w_empty;

  // Pipeline has priority; aux head drains only in pipe bubbles, dst 0 entries are dropped
  always_comb begin
    w_rf_we      = 1'b0;
    w_rf_wa      = '0;
    w_rf_wd      = '0;
    w_rf_src_aux = 1'b0;
    if (w_pipe_wr) begin
      w_rf_we = 1'b1;
      w_rf_wa = r_w.dst;
      w_rf_wd = w_result;
    end else if (!w_empty) begin
      w_rf_we      = (r_q_dst[r_rp] != '0);
      w_rf_wa      = r_q_dst[r_rp];
      w_rf_wd      = r_q_data[r_rp];
      w_rf_src_aux = 1'b1;
    end
  end

  // FIFO storage carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_dst[r_wp]  <= bus.aux_dst;
      r_q_data[r_wp] <= bus.aux_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.rf_we      = w_rf_we;
  assign bus.rf_wa      = w_rf_wa;
  assign bus.rf_wd      = w_rf_wd;
  assign bus.rf_src_aux = w_rf_src_aux;
  assign bus.aux_ready  = ~w_full;
  assign bus.aux_count  = r_cnt;
  assign bus.misalign   = r_w.valid & (r_w.sel == 2'd1) &
                          ((r_w.ld == 3'd3) | (r_w.ld == 3'd4)) & r_w.off[0];
endmodule
